// File: rtl/rx_frame_ctrl.sv
// Oversampled asynchronous serial receiver: start/data/parity/stop framing
// with a single-entry output buffer, parity/framing error flags and sticky overrun.
module rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  BaudTick,
    input  logic                  RxIn,
    input  logic                  ParityEn,
    input  logic                  ParityOdd,
    input  logic                  DataReady,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  DataValid,
    output logic                  ParityErr,
    output logic                  FrameErr,
    output logic                  Overrun,
    output logic                  Busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state, state_next;
    logic                    rx_meta, rxs;
    logic [CW-1:0]           cnt;
    logic [BW-1:0]           bit_idx;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    par_en_l, par_odd_l, par_err_l, frame_err_l;
    logic                    done;
    logic                    cnt_clr, cnt_inc, shift_en, cfg_latch, par_sample, stop_sample;

    assign Busy = (state != IDLE);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        shift_en    = 1'b0;
        cfg_latch   = 1'b0;
        par_sample  = 1'b0;
        stop_sample = 1'b0;
        if (BaudTick) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state_next = START;
                        cnt_clr    = 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        if (rxs) begin
                            state_next = IDLE;
                        end else begin
                            state_next = DATA;
                            cnt_clr    = 1'b1;
                            cfg_latch  = 1'b1;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        shift_en = 1'b1;
                        cnt_clr  = 1'b1;
                        if (bit_idx == BIT_LAST) state_next = par_en_l ? PARITY : STOP;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        par_sample = 1'b1;
                        cnt_clr    = 1'b1;
                        state_next = STOP;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        stop_sample = 1'b1;
                        cnt_clr     = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments throughout, so every read sees the pre-edge value.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            rx_meta     <= 1'b1;
            rxs         <= 1'b1;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            par_en_l    <= 1'b0;
            par_odd_l   <= 1'b0;
            par_err_l   <= 1'b0;
            frame_err_l <= 1'b0;
            done        <= 1'b0;
            DataOut     <= '0;
            DataValid   <= 1'b0;
            ParityErr   <= 1'b0;
            FrameErr    <= 1'b0;
            Overrun     <= 1'b0;
        end else begin
            rx_meta <= RxIn;
            rxs     <= rx_meta;
            state   <= state_next;

            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;

            if (cfg_latch) begin
                bit_idx   <= '0;
                par_en_l  <= ParityEn;
                par_odd_l <= ParityOdd;
                par_err_l <= 1'b0;
            end
            if (shift_en) begin
                shreg   <= {rxs, shreg[DATA_WIDTH-1:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (par_sample)  par_err_l   <= ((^shreg) ^ rxs) != par_odd_l;
            if (stop_sample) frame_err_l <= ~rxs;

            // Word is handed to the buffer one cycle after the stop-bit sample.
            done <= stop_sample;

            if (done && (!DataValid || DataReady)) begin
                DataOut   <= shreg;
                ParityErr <= par_err_l;
                FrameErr  <= frame_err_l;
                DataValid <= 1'b1;
            end else if (DataValid && DataReady) begin
                DataValid <= 1'b0;
            end

            if (done && DataValid && !DataReady) Overrun <= 1'b1;
            else if (DataValid && DataReady)     Overrun <= 1'b0;
        end
    end

endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 SHALL provide parameters, one per line:
- DATA_WIDTH, 8, data bits per frame.
- OVERSAMPLE, 16, BaudTick pulses per bit period (even, >=4).

REQ-002 SHALL provide ports, one per line:
- Clock, in, 1, system clock (50 MHz).
- Reset, in, 1, synchronous, active-high reset.
- BaudTick, in, 1, one-Clock pulse at OVERSAMPLE x baud, from the baud generator.
- RxIn, in, 1, asynchronous serial line, idle high.
- ParityEn, in, 1, parity bit present.
- ParityOdd, in, 1, 1 = odd parity, 0 = even parity.
- DataReady, in, 1, consumer accepts DataOut.
- DataOut, out, DATA_WIDTH, received word.
- DataValid, out, 1, DataOut holds an unconsumed word.
- ParityErr, out, 1, parity mismatch for the word in DataOut.
- FrameErr, out, 1, stop bit was 0 for the word in DataOut.
- Overrun, out, 1, sticky: a completed frame was dropped.
- Busy, out, 1, frame reception in progress.

REQ-003 SHALL use one clock domain (Clock); reset SHALL be synchronous and active-high on port Reset.

Function
REQ-004 SHALL pass RxIn through a 2-flop synchronizer (flops reset to 1); all line decisions use the synchronized value rxs.

REQ-005 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; Busy = (state != IDLE).

REQ-006 SHALL keep a tick counter cnt of width clog2(OVERSAMPLE); cnt advances only on Clock edges where BaudTick=1.

REQ-007 SHALL handle IDLE: on a BaudTick with rxs=0, go to START and set cnt=0.

REQ-008 SHALL handle START: on the BaudTick where cnt==OVERSAMPLE/2-1:
- rxs=1: false start, return to IDLE, no outputs change.
- rxs=0: cnt=0, bit index=0, latch ParityEn/ParityOdd, go to DATA.

REQ-009 SHALL handle DATA: on each BaudTick where cnt==OVERSAMPLE-1, sample rxs into shift register LSB-first, cnt wraps to 0, bit index increments. After DATA_WIDTH samples, go to PARITY if latched ParityEn=1, else STOP.

REQ-010 SHALL handle PARITY: sample at cnt==OVERSAMPLE-1. Error = (XOR of data bits XOR parity bit) != latched ParityOdd. Then go to STOP.

REQ-011 SHALL handle STOP: sample at cnt==OVERSAMPLE-1. Stop-bit value 0 flags a frame error. Frame completes; return to IDLE in the same transition.

REQ-012 SHALL, on the Clock edge after the stop-bit sampling tick (frame completion), load DataOut, ParityErr and FrameErr and set DataValid=1, provided the output buffer is free.

REQ-013 SHALL treat the buffer as free when DataValid=0, or when DataValid=1 and DataReady=1 in the completion cycle; in the latter case the new word loads and DataValid stays 1.

REQ-014 SHALL, on completion with DataValid=1 and DataReady=0, drop the new word, keep DataOut/ParityErr/FrameErr unchanged, and set Overrun=1.

REQ-015 SHALL clear DataValid on the edge after a cycle with DataValid=1 and DataReady=1 (no new load); Overrun SHALL clear on that same handshake.

REQ-016 SHALL ignore DataReady while DataValid=0.

REQ-017 SHALL ignore changes to ParityEn/ParityOdd mid-frame (values latched per REQ-008).

REQ-018 SHALL still advance the FSM when a frame error occurs; no resynchronisation beyond a return to IDLE.

Reset
REQ-019 SHALL, on Reset=1 at a Clock edge, set: state=IDLE, cnt=0, synchronizer=1, DataOut=0, DataValid=0, ParityErr=0, FrameErr=0, Overrun=0, Busy=0.

REQ-020 SHALL let Reset abort any frame in progress with no partial output; reception restarts from the first falling edge after Reset deasserts.

Verification
REQ-021 SHALL cover reset mid-frame: assert Reset during DATA bit 3 -> next cycle all outputs 0, Busy=0; the subsequent frame 0x3C is received correctly.

REQ-022 SHALL cover a clean frame: BaudTick=1 every cycle, ParityEn=0, frame 0xA5 with stop=1, DataReady=1 -> DataValid high exactly 1 cycle, DataOut=0xA5, ParityErr=FrameErr=Overrun=0.

REQ-023 SHALL cover a false start: RxIn low 4 ticks then high -> Busy high then returns to 0 at cnt=7; DataValid never asserts.

REQ-024 SHALL cover parity and framing errors:
- ParityEn=1, ParityOdd=0, data 0x03, parity bit 1 -> DataOut=0x03, ParityErr=1.
- Next frame 0x7E with stop bit 0 -> FrameErr=1, ParityErr=0.

REQ-025 SHALL cover overrun: DataReady=0, frames 0x11 then 0x22 -> DataOut=0x11, Overrun=1. Then DataReady=1 for one cycle -> DataValid=0, Overrun=0.

REQ-026 SHALL cover a simultaneous event: frame 0x44 completes in the same cycle DataValid=1 and DataReady=1 (old 0x33) -> DataOut=0x44, DataValid stays 1, Overrun=0.
